// File: rtl/mimo_frame_loader.sv
// MIMO frame loader: collects a channel matrix H and ping-pong Y slot banks,
// then presents a complete (H, Y) frame for random-access reads until released.
module mimo_frame_loader #(
    parameter int N     = 32,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int YCOLS = 2,
    localparam int HSZ  = ROWS * COLS,
    localparam int YSZ  = ROWS * YCOLS,
    localparam int AW   = $clog2((HSZ > YSZ) ? HSZ : YSZ)
) (
    input  logic          CLOCK_50,
    input  logic          sys_rst,
    input  logic          i_h_reuse,
    input  logic          i_H_valid,
    output logic          o_H_ready,
    input  logic [N-1:0]  i_H_r,
    input  logic [N-1:0]  i_H_i,
    input  logic          i_Y_valid,
    output logic          o_Y_ready,
    input  logic [N-1:0]  i_Y_r,
    input  logic [N-1:0]  i_Y_i,
    output logic          o_frame_valid,
    input  logic          i_rd_sel,
    input  logic [AW-1:0] i_rd_addr,
    output logic [N-1:0]  o_rd_r,
    output logic [N-1:0]  o_rd_i,
    input  logic          i_frame_done,
    output logic [15:0]   o_frame_cnt,
    output logic          o_ovf
);

    localparam int HAW = (HSZ > 1) ? $clog2(HSZ) : 1;
    localparam int YAW = (YSZ > 1) ? $clog2(YSZ) : 1;
    localparam logic [AW-1:0] H_LAST = AW'(HSZ - 1);
    localparam logic [AW-1:0] Y_LAST = AW'(YSZ - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_YDONE = 2'd2,
        ST_FULL  = 2'd3
    } bank_st_t;

    bank_st_t      r_bank_st      [2];
    bank_st_t      w_bank_st_next [2];
    logic          r_wr_ptr, w_wr_ptr_next;
    logic          r_rd_ptr, w_rd_ptr_next;
    logic [AW-1:0] r_y_cnt, w_y_cnt_next;
    logic [AW-1:0] r_h_cnt, w_h_cnt_next;
    logic          r_h_loaded, w_h_loaded_next;
    logic          r_frame_valid, w_frame_valid_next;
    logic [15:0]   r_frame_cnt, w_frame_cnt_next;
    logic          r_ovf, w_ovf_next;

    logic          w_any_full, w_y_ready, w_h_ready;
    logic          w_y_acc, w_h_acc, w_y_last, w_h_last;
    logic          w_release, w_promote;

    logic          r_rd_sel, r_rd_bank, r_rd_zero, w_rd_oob;
    logic [2*N-1:0] r_h_q;
    logic [2*N-1:0] w_y_q [2];
    logic [2*N-1:0] w_rd_word;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge sys_rst) begin
        if (sys_rst) begin
            for (int b = 0; b < 2; b++) begin
                r_bank_st[b] <= ST_EMPTY;
            end
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_y_cnt       <= '0;
            r_h_cnt       <= '0;
            r_h_loaded    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= '0;
            r_ovf         <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_bank_st[b] <= w_bank_st_next[b];
            end
            r_wr_ptr      <= w_wr_ptr_next;
            r_rd_ptr      <= w_rd_ptr_next;
            r_y_cnt       <= w_y_cnt_next;
            r_h_cnt       <= w_h_cnt_next;
            r_h_loaded    <= w_h_loaded_next;
            r_frame_valid <= w_frame_valid_next;
            r_frame_cnt   <= w_frame_cnt_next;
            r_ovf         <= w_ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_y_acc   = i_Y_valid && w_y_ready;
        w_h_acc   = i_H_valid && w_h_ready;
        w_y_last  = (r_y_cnt == Y_LAST);
        w_h_last  = (r_h_cnt == H_LAST);
        // The read pointer always names the oldest unreleased bank, so a
        // release and a promotion can never target the same bank on one edge.
        w_release = i_frame_done && r_frame_valid && (r_bank_st[r_rd_ptr] == ST_FULL);
        w_promote = (r_bank_st[r_rd_ptr] == ST_YDONE) && r_h_loaded
                    && (r_bank_st[!r_rd_ptr] != ST_FULL);

        w_wr_ptr_next = r_wr_ptr ^ (w_y_acc && w_y_last);
        w_rd_ptr_next = r_rd_ptr ^ w_release;

        w_y_cnt_next = r_y_cnt;
        if (w_y_acc) begin
            w_y_cnt_next = w_y_last ? '0 : r_y_cnt + AW'(1);
        end

        w_h_cnt_next    = r_h_cnt;
        w_h_loaded_next = r_h_loaded;
        if (w_h_acc) begin
            w_h_cnt_next    = w_h_last ? '0 : r_h_cnt + AW'(1);
            w_h_loaded_next = w_h_last;
        end else if (w_promote && !i_h_reuse) begin
            w_h_loaded_next = 1'b0;
        end

        w_frame_valid_next = (r_bank_st[r_rd_ptr] == ST_FULL);
        w_frame_cnt_next   = r_frame_cnt + {15'd0, w_release};
        w_ovf_next         = r_ovf || (i_H_valid && !w_h_ready) || (i_Y_valid && !w_y_ready);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            bank_st_t       w_st_nx;
            logic [2*N-1:0] r_y_mem [YSZ];
            logic [2*N-1:0] r_y_q;

            always_comb begin
                w_st_nx = r_bank_st[gi];
                if (w_y_acc && (r_wr_ptr == 1'(gi))) begin
                    w_st_nx = w_y_last ? ST_YDONE : ST_FILL;
                end else if (w_promote && (r_rd_ptr == 1'(gi))) begin
                    w_st_nx = ST_FULL;
                end else if (w_release && (r_rd_ptr == 1'(gi))) begin
                    w_st_nx = ST_EMPTY;
                end
            end
            assign w_bank_st_next[gi] = w_st_nx;

            always_ff @(posedge CLOCK_50) begin
                if (w_y_acc && (r_wr_ptr == 1'(gi))) begin
                    r_y_mem[r_y_cnt[YAW-1:0]] <= {i_Y_r, i_Y_i};
                end
                r_y_q <= r_y_mem[i_rd_addr[YAW-1:0]];
            end
            assign w_y_q[gi] = r_y_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // H storage and read path
    // ------------------------------------------------------------------
    logic [2*N-1:0] r_h_mem [HSZ];

    always_ff @(posedge CLOCK_50) begin
        if (w_h_acc) begin
            r_h_mem[r_h_cnt[HAW-1:0]] <= {i_H_r, i_H_i};
        end
        r_h_q <= r_h_mem[i_rd_addr[HAW-1:0]];
    end

    assign w_rd_oob = i_rd_sel ? ({1'b0, i_rd_addr} >= (AW+1)'(YSZ))
                               : ({1'b0, i_rd_addr} >= (AW+1)'(HSZ));

    // Control side of the read pipeline; zero flag doubles as reset blanking.
    always_ff @(posedge CLOCK_50 or posedge sys_rst) begin
        if (sys_rst) begin
            r_rd_sel  <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            r_rd_sel  <= i_rd_sel;
            r_rd_bank <= r_rd_ptr;
            r_rd_zero <= w_rd_oob;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_any_full = (r_bank_st[0] == ST_FULL) || (r_bank_st[1] == ST_FULL);
        w_y_ready  = (r_bank_st[r_wr_ptr] == ST_EMPTY) || (r_bank_st[r_wr_ptr] == ST_FILL);
        w_h_ready  = !((r_h_cnt == '0) && (w_any_full || (r_h_loaded && !i_h_reuse)));
        w_rd_word  = r_rd_sel ? w_y_q[r_rd_bank] : r_h_q;

        o_H_ready     = w_h_ready;
        o_Y_ready     = w_y_ready;
        o_frame_valid = r_frame_valid;
        o_frame_cnt   = r_frame_cnt;
        o_ovf         = r_ovf;
        o_rd_r        = r_rd_zero ? '0 : w_rd_word[2*N-1:N];
        o_rd_i        = r_rd_zero ? '0 : w_rd_word[N-1:0];
    end

endmodule

// File: doc/mimo_frame_loader.md
MIMO_FRAME_LOADER -- requirements
Module: mimo_frame_loader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N, 32, complex component width in bits (signed).
- ROWS, 4, receive antennas, i.e. H and Y rows.
- COLS, 4, H columns.
- YCOLS, 2, Y columns (time slots).
REQ-002 Derived sizes: HSZ=ROWS*COLS; YSZ=ROWS*YCOLS; AW=clog2(max(HSZ,YSZ)).
REQ-003 Ports, one per line: name  direction  width  meaning.
- CLOCK_50  in  1  single clock, rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- i_h_reuse  in  1  1 = keep H across frames; static, changed only while all banks EMPTY.
- i_H_valid / o_H_ready  in/out  1  H write handshake.
- i_H_r, i_H_i  in  N  H entry, row-major order.
- i_Y_valid / o_Y_ready  in/out  1  Y write handshake.
- i_Y_r, i_Y_i  in  N  Y entry, arrival order.
- o_frame_valid  out  1  a complete frame (H+Y) is readable.
- i_rd_sel  in  1  0 = H, 1 = Y.
- i_rd_addr  in  AW  read index.
- o_rd_r, o_rd_i  out  N  read data.
- i_frame_done  in  1  single-cycle pulse; releases the current frame.
- o_frame_cnt  out  16  count of released frames, wraps at 65535 -> 0.
- o_ovf  out  1  sticky; a valid was presented while ready=0.

Function
REQ-004 A write is accepted when valid && ready on a rising edge; H at h_cnt, Y at y_cnt of the write bank; each counter then increments.
REQ-005 Y storage is two ping-pong banks; H storage is one bank plus an h_loaded flag.
REQ-006 Per-bank states: EMPTY -> FILL (first Y write) -> YDONE (YSZ-th write) -> FULL -> EMPTY (i_frame_done).
REQ-007 On EMPTY->FILL or FILL->YDONE the write pointer toggles at YDONE, and y_cnt returns to 0.
REQ-008 YDONE->FULL when h_loaded=1 and the other bank is not FULL; banks promote in write order.
REQ-009 h_cnt reaching HSZ sets h_loaded and resets h_cnt to 0.
REQ-010 When i_h_reuse=0, promotion to FULL clears h_loaded; i_h_reuse=1 leaves it set.
REQ-011 o_Y_ready=1 iff the write bank is EMPTY or FILL.
REQ-012 o_H_ready=0 iff h_cnt=0 and (any bank FULL, or h_loaded=1 with i_h_reuse=0); otherwise 1.
REQ-013 Writes to H while h_loaded=1 with i_h_reuse=1 overwrite entries in order; h_loaded is cleared on the first such write until HSZ is reached again.
REQ-014 o_frame_valid is registered: high the cycle after a bank enters FULL, low the cycle after i_frame_done.
REQ-015 i_frame_done while o_frame_valid=0 is ignored.
REQ-016 If release and a YDONE->FULL promotion fall on the same edge, release takes priority; promotion occurs on the next edge and o_frame_valid drops for exactly one cycle.
REQ-017 Read data is registered, 1-cycle latency, from the FULL bank (Y) or the H bank.
REQ-018 Addresses at or above HSZ (H) or YSZ (Y) return 0.
REQ-019 o_frame_cnt increments on each accepted i_frame_done.
REQ-020 o_ovf sets on (i_H_valid && !o_H_ready) or (i_Y_valid && !o_Y_ready) and clears only on reset.

Reset
REQ-021 While sys_rst=1: all outputs 0 except o_H_ready=1 and o_Y_ready=1.
REQ-022 While sys_rst=1: both banks EMPTY, h_cnt=y_cnt=0, h_loaded=0, write and read pointers on bank 0.
REQ-023 Storage arrays are not reset.
REQ-024 Reset mid-load discards partial data; after reset, loading resumes at index 0.

Verification (ROWS=4, COLS=4, YCOLS=2, i_h_reuse=1 unless stated)
REQ-025 16 H and 8 Y writes start on the same edge -> o_frame_valid=1 two cycles after the 16th H write; H read at addr 5 returns the 6th H entry one cycle later.
REQ-026 After a done pulse, 8 Y writes only -> o_frame_valid=1 again with unchanged H; o_frame_cnt=1.
REQ-027 i_h_reuse=0: after a done pulse, 8 Y writes -> o_frame_valid stays 0; 16 H writes -> frame valid; o_H_ready=0 while the frame is FULL.
REQ-028 Three back-to-back Y frames with no done pulse -> third frame stalls (o_Y_ready=0); valid held -> o_ovf=1; done -> second frame valid after a one-cycle gap.
REQ-029 sys_rst pulse after 7 H writes -> outputs return to reset values; a fresh 16+8 load produces a correct frame.
REQ-030 i_frame_done with o_frame_valid=0 -> no state change; o_frame_cnt stays 0.
